// File: rtl/data_mem_arb_pkg.sv
// Shared types and constants for the data memory arbiter.
package data_mem_arb_pkg;

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

   localparam int unsigned REQ_CPU    = 0;
   localparam int unsigned REQ_LOADER = 1;
   localparam int unsigned NUM_REQ    = 2;

   // One-hot vector selecting requester id.
   function automatic logic [NUM_REQ-1:0] req_onehot(input logic id);
      return NUM_REQ'(1) << id;
   endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin picker: on a tie, the requester that did not win last time wins.
module rr_arbiter2
   import data_mem_arb_pkg::*;
(
   input  logic [NUM_REQ-1:0] req,
   input  logic               last_grant,
   output logic               grant_valid,
   output logic               grant_id
);

   // Loader wins when it is alone, or on a tie after the CPU was served last.
   always_comb begin
      grant_valid = |req;
      grant_id    = req[REQ_LOADER] &&
                    (!req[REQ_CPU] || (last_grant == 1'(REQ_CPU)));
   end

endmodule

// File: rtl/data_mem_arbiter.sv
// Shares the single-port data memory between the MEM stage and the loader port.
// One outstanding transaction, sequenced IDLE -> ISSUE -> (WAIT) -> RESP -> IDLE.
module data_mem_arbiter
   import data_mem_arb_pkg::*;
#(
   parameter int unsigned ADDR_W    = 32,
   parameter int unsigned DATA_W    = 32,
   parameter int unsigned MEM_DEPTH = 1024,
   parameter int unsigned READ_LAT  = 1
)(
   input  logic                            clk,
   input  logic                            rst,
   input  logic [NUM_REQ-1:0]              req,
   input  logic [NUM_REQ-1:0]              we,
   input  logic [NUM_REQ-1:0][ADDR_W-1:0]  addr,
   input  logic [NUM_REQ-1:0][DATA_W-1:0]  wdata,
   output logic [NUM_REQ-1:0]              gnt,
   output logic [NUM_REQ-1:0]              ack,
   output logic [DATA_W-1:0]               rdata,
   output logic                            err,
   output logic                            busy,
   output logic [ADDR_W-1:0]               mem_addr,
   output logic [DATA_W-1:0]               mem_wdata,
   output logic                            mem_we,
   input  logic [DATA_W-1:0]               mem_rdata
);

   localparam int unsigned CNT_W = 3;

   state_t              state, state_next;
   logic                id, id_next;
   logic                acc_we, acc_we_next;
   logic                acc_oor, acc_oor_next;
   logic [CNT_W-1:0]    cnt, cnt_next;
   logic                last_grant, last_grant_next;
   logic [NUM_REQ-1:0]  gnt_next, ack_next;
   logic                err_next, mem_we_next, busy_next;
   logic [DATA_W-1:0]   rdata_next, mem_wdata_next;
   logic [ADDR_W-1:0]   mem_addr_next;
   logic                grant_valid_c, grant_id_c, sel_oor_c;

   rr_arbiter2 u_arb (
      .req         (req),
      .last_grant  (last_grant),
      .grant_valid (grant_valid_c),
      .grant_id    (grant_id_c)
   );

   // Range check of the address offered by the current winner.
   assign sel_oor_c = (addr[grant_id_c] >= ADDR_W'(MEM_DEPTH));

   // Next-state and next-output decode; every output is registered from these.
   always_comb begin
      state_next      = state;
      id_next         = id;
      acc_we_next     = acc_we;
      acc_oor_next    = acc_oor;
      cnt_next        = cnt;
      last_grant_next = last_grant;
      gnt_next        = '0;
      ack_next        = '0;
      err_next        = 1'b0;
      mem_we_next     = 1'b0;
      rdata_next      = rdata;
      mem_addr_next   = mem_addr;
      mem_wdata_next  = mem_wdata;
      case (state)
         IDLE: begin
            if (grant_valid_c) begin
               state_next      = ISSUE;
               id_next         = grant_id_c;
               acc_we_next     = we[grant_id_c];
               acc_oor_next    = sel_oor_c;
               last_grant_next = grant_id_c;
               gnt_next        = req_onehot(grant_id_c);
               mem_addr_next   = addr[grant_id_c];
               mem_wdata_next  = wdata[grant_id_c];
               mem_we_next     = we[grant_id_c] && !sel_oor_c;
            end
         end
         ISSUE: begin
            if (acc_we || acc_oor) begin
               state_next = RESP;
               ack_next   = req_onehot(id);
               err_next   = acc_oor;
               if (!acc_we) rdata_next = '0;
            end else begin
               state_next = WAIT;
               cnt_next   = CNT_W'(READ_LAT - 1);
            end
         end
         WAIT: begin
            if (cnt == '0) begin
               state_next = RESP;
               rdata_next = mem_rdata;
               ack_next   = req_onehot(id);
            end else begin
               cnt_next = cnt - CNT_W'(1);
            end
         end
         RESP: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
      busy_next = (state_next != IDLE);
   end

   // State and output registers; reset aborts any transaction in flight.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         id         <= 1'b0;
         acc_we     <= 1'b0;
         acc_oor    <= 1'b0;
         cnt        <= '0;
         last_grant <= 1'(REQ_LOADER);
         gnt        <= '0;
         ack        <= '0;
         err        <= 1'b0;
         busy       <= 1'b0;
         mem_we     <= 1'b0;
         rdata      <= '0;
         mem_addr   <= '0;
         mem_wdata  <= '0;
      end else begin
         state      <= state_next;
         id         <= id_next;
         acc_we     <= acc_we_next;
         acc_oor    <= acc_oor_next;
         cnt        <= cnt_next;
         last_grant <= last_grant_next;
         gnt        <= gnt_next;
         ack        <= ack_next;
         err        <= err_next;
         busy       <= busy_next;
         mem_we     <= mem_we_next;
         rdata      <= rdata_next;
         mem_addr   <= mem_addr_next;
         mem_wdata  <= mem_wdata_next;
      end
   end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed bench for data_mem_arbiter with a synchronous-read memory model (READ_LAT=1).
module tb_data_mem_arbiter;

   localparam int unsigned READ_LAT = 1;

   logic              clk = 1'b0;
   logic              rst;
   logic [1:0]        req, we;
   logic [1:0][31:0]  addr, wdata;
   logic [1:0]        gnt, ack;
   logic [31:0]       rdata, mem_addr, mem_wdata, mem_rdata;
   logic              err, busy, mem_we;

   logic [31:0] mem [0:1023];
   int total = 0;
   int bad   = 0;

   data_mem_arbiter #(
      .ADDR_W(32), .DATA_W(32), .MEM_DEPTH(1024), .READ_LAT(READ_LAT)
   ) dut (
      .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata),
      .gnt(gnt), .ack(ack), .rdata(rdata), .err(err), .busy(busy),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
      .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   // Memory model: one-cycle synchronous read, write on mem_we.
   always @(posedge clk) begin
      if (mem_we && mem_addr < 32'd1024) mem[mem_addr[9:0]] <= mem_wdata;
      mem_rdata <= mem[mem_addr[9:0]];
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=0x%08h expected=0x%08h at %0t", tag, got, exp, $time);
      end
   endtask

   // One isolated access; checks gnt timing, ack latency, err, rdata and mem_we pulses.
   task automatic access(input int id, input logic w, input logic [31:0] a,
                         input logic [31:0] d, input int exp_lat, input logic exp_err,
                         input logic [31:0] exp_rd, input int exp_we_cnt);
      int n;
      int we_cnt;
      logic [1:0] oh;
      oh = 2'b01 << id;
      @(posedge clk); #1;
      req[id] = 1'b1; we[id] = w; addr[id] = a; wdata[id] = d;
      @(negedge clk);
      chk("gnt_in_T", 32'(gnt), 32'd0);
      @(negedge clk);
      chk("gnt", 32'(gnt), 32'(oh));
      req[id] = 1'b0; we[id] = ~w; addr[id] = ~a; wdata[id] = ~d;
      n = 1;
      we_cnt = int'(mem_we);
      while (ack == 2'b00 && n < 20) begin
         @(negedge clk);
         n++;
         we_cnt += int'(mem_we);
      end
      chk("ack_lat", 32'(n), 32'(exp_lat));
      chk("ack", 32'(ack), 32'(oh));
      chk("err", 32'(err), 32'(exp_err));
      chk("rdata", rdata, exp_rd);
      chk("mem_we_cnt", 32'(we_cnt), 32'(exp_we_cnt));
      @(negedge clk);
      chk("ack_clr", 32'(ack), 32'd0);
      chk("busy_clr", 32'(busy), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not end, total=%0d", total);
      $fatal(1, "watchdog");
   end

   initial begin
      int ng, na, cyc, last_cyc, gid, n;
      logic [1:0] exp_g;
      for (int i = 0; i < 1024; i++) mem[i] = 32'h1000 + 32'(i);
      rst = 1'b1; req = '0; we = '0; addr = '0; wdata = '0;

      // Reset
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_gnt", 32'(gnt), 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      chk("idle_gnt", 32'(gnt), 32'd0);
      chk("idle_ack", 32'(ack), 32'd0);
      chk("idle_busy", 32'(busy), 32'd0);
      chk("idle_mem_we", 32'(mem_we), 32'd0);
      chk("idle_rdata", rdata, 32'd0);

      // Write then read, out-of-range write and read
      access(0, 1'b1, 32'd4, 32'h7, 2, 1'b0, 32'd0, 1);
      chk("mem4", mem[4], 32'h7);
      access(0, 1'b0, 32'd4, 32'h0, 2 + int'(READ_LAT), 1'b0, 32'h7, 0);
      access(1, 1'b1, 32'd1024, 32'hDEAD, 2, 1'b1, 32'h7, 0);
      access(1, 1'b0, 32'd2000, 32'h0, 2, 1'b1, 32'h0, 0);

      // Contention: both read continuously, grants alternate starting with 0
      @(posedge clk); #1;
      we = 2'b00; addr[0] = 32'd0; addr[1] = 32'd1; req = 2'b11;
      ng = 0; na = 0; cyc = 0; last_cyc = 0;
      while (na < 4 && cyc < 80) begin
         @(negedge clk);
         cyc++;
         if (gnt != 2'b00) begin
            gid = gnt[1] ? 1 : 0;
            chk("rr_order", 32'(gid), 32'(ng % 2));
            if (ng > 0) chk("rr_gap", 32'(cyc - last_cyc), 32'(3 + READ_LAT));
            last_cyc = cyc;
            ng++;
            if (ng == 4) req = 2'b00;
         end
         if (ack != 2'b00) begin
            gid = ack[1] ? 1 : 0;
            chk("rr_rdata", rdata, 32'h1000 + 32'(gid));
            na++;
         end
      end
      chk("rr_acks", 32'(na), 32'd4);
      @(negedge clk);

      // Busy masking: req1 rises during WAIT of a req0 read
      @(posedge clk); #1;
      req[0] = 1'b1; we = 2'b00; addr[0] = 32'd0; addr[1] = 32'd1;
      for (int c = 0; c <= 5; c++) begin
         @(negedge clk);
         exp_g = (c == 1) ? 2'b01 : ((c == 5) ? 2'b10 : 2'b00);
         chk("mask_gnt", 32'(gnt), 32'(exp_g));
         if (c == 1) req[0] = 1'b0;
         if (c == 2) req[1] = 1'b1;
         if (c == 3) chk("mask_ack0", 32'(ack), 32'h1);
         if (c == 5) req[1] = 1'b0;
      end
      n = 0;
      while (ack == 2'b00 && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("mask_ack1", 32'(ack), 32'h2);
      chk("mask_rdata1", rdata, 32'h1001);
      @(negedge clk);

      // Mid-op reset during ISSUE of a write
      @(posedge clk); #1;
      req[0] = 1'b1; we[0] = 1'b1; addr[0] = 32'd8; wdata[0] = 32'h55;
      @(negedge clk);
      @(negedge clk);
      chk("mid_gnt_pre", 32'(gnt), 32'h1);
      chk("mid_we_pre", 32'(mem_we), 32'h1);
      rst = 1'b1;
      #1;
      chk("mid_gnt", 32'(gnt), 32'd0);
      chk("mid_mem_we", 32'(mem_we), 32'd0);
      chk("mid_ack", 32'(ack), 32'd0);
      chk("mid_busy", 32'(busy), 32'd0);
      req = 2'b00;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         chk("post_rst_ack", 32'(ack), 32'd0);
         chk("post_rst_busy", 32'(busy), 32'd0);
      end
      access(0, 1'b0, 32'd4, 32'h0, 2 + int'(READ_LAT), 1'b0, 32'h7, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
